// File: rtl/iiq_pkg.sv
// Shared types for the integer issue queue: entry layout and width defaults.
package iiq_pkg;

    localparam int TAG_WIDTH     = 5;
    localparam int PAYLOAD_WIDTH = 32;

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic                     dst_valid;
        logic [TAG_WIDTH-1:0]     dst_tag;
        logic                     src2_ready;
        logic [TAG_WIDTH-1:0]     src2_tag;
        logic                     src1_ready;
        logic [TAG_WIDTH-1:0]     src1_tag;
    } iiq_entry_t;

endpackage

// File: rtl/priority_onehot_sel.sv
// Lowest-index-first one-hot picker; all zeros when nothing is requested.
module priority_onehot_sel #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o
);
    import iiq_pkg::*;

    // Two's-complement isolates the lowest set bit.
    assign gnt_o = req_i & (~req_i + WIDTH'(1));

endmodule

// File: rtl/iiq_issue_scheduler.sv
// Integer issue-queue consumer: CDB wakeup, oldest-ready select, one-deep issue register.
// Optional IIQ_SPEC_WAKEUP_EN adds a one-cycle self-wake from the op just dequeued.
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 8
`endif
module iiq_issue_scheduler #(
    parameter int N_ENTRIES     = `IIQ_N_ENTRIES,
    parameter int TAG_WIDTH     = iiq_pkg::TAG_WIDTH,
    parameter int PAYLOAD_WIDTH = iiq_pkg::PAYLOAD_WIDTH,
    localparam int ENTRY_WIDTH  = PAYLOAD_WIDTH + 3*TAG_WIDTH + 3,
    localparam int CTR_WIDTH    = $clog2(N_ENTRIES) + 1
) (
    input  logic                             clk,
    input  logic                             rst_aL,
    input  logic                             flush,
    input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] entry_douts,
    input  logic [CTR_WIDTH-1:0]             entry_count,
    output logic                             deq_ready,
    output logic [N_ENTRIES-1:0]             deq_sel_onehot,
    input  logic                             deq_valid,
    input  logic [ENTRY_WIDTH-1:0]           deq_data,
    output logic [N_ENTRIES-1:0]             wr_en,
    output logic [N_ENTRIES*ENTRY_WIDTH-1:0] wr_data,
    input  logic                             cdb_valid,
    input  logic [TAG_WIDTH-1:0]             cdb_tag,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic [ENTRY_WIDTH-1:0]           iss_data
);
    import iiq_pkg::*;

    // Field positions matching iiq_entry_t, kept parametric in the tag width.
    localparam int S1T = 0;
    localparam int S1R = TAG_WIDTH;
    localparam int S2T = TAG_WIDTH + 1;
    localparam int S2R = 2*TAG_WIDTH + 1;
    localparam int DT  = 2*TAG_WIDTH + 2;
    localparam int DV  = 3*TAG_WIDTH + 2;

    logic [N_ENTRIES-1:0]   rdy;
    logic [N_ENTRIES-1:0]   sel_raw;
    logic                   can_load;
    logic                   deq_fire;
    logic                   iss_valid_q, iss_valid_d;
    logic [ENTRY_WIDTH-1:0] iss_data_q, iss_data_d;

`ifdef IIQ_SPEC_WAKEUP_EN
    logic                 self_valid_q, self_valid_d;
    logic [TAG_WIDTH-1:0] self_tag_q, self_tag_d;
`endif

    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_ent
        logic [ENTRY_WIDTH-1:0] e, w;
        logic [TAG_WIDTH-1:0]   t1, t2;
        logic                   r1, r2, m1, m2, in_q;

        assign e    = entry_douts[gi*ENTRY_WIDTH +: ENTRY_WIDTH];
        assign t1   = e[S1T +: TAG_WIDTH];
        assign t2   = e[S2T +: TAG_WIDTH];
        assign r1   = e[S1R];
        assign r2   = e[S2R];
        assign in_q = CTR_WIDTH'(gi) < entry_count;
`ifdef IIQ_SPEC_WAKEUP_EN
        assign m1 = (cdb_valid && cdb_tag == t1) || (self_valid_q && self_tag_q == t1);
        assign m2 = (cdb_valid && cdb_tag == t2) || (self_valid_q && self_tag_q == t2);
`else
        assign m1 = cdb_valid && cdb_tag == t1;
        assign m2 = cdb_valid && cdb_tag == t2;
`endif
        assign rdy[gi]   = in_q & (r1 | m1) & (r2 | m2);
        // An entry leaving this cycle must not be rewritten behind the shift.
        assign wr_en[gi] = in_q & ((m1 & ~r1) | (m2 & ~r2)) & ~deq_sel_onehot[gi];

        always_comb begin
            w      = e;
            w[S1R] = r1 | m1;
            w[S2R] = r2 | m2;
        end
        assign wr_data[gi*ENTRY_WIDTH +: ENTRY_WIDTH] = w;
    end

    priority_onehot_sel #(.WIDTH(N_ENTRIES)) u_sel (
        .req_i (rdy),
        .gnt_o (sel_raw)
    );

    assign can_load       = ~iss_valid_q | iss_ready;
    assign deq_ready      = can_load & ~flush;
    assign deq_sel_onehot = deq_ready ? sel_raw : '0;
    assign deq_fire       = deq_ready & deq_valid;

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_data_d  = iss_data_q;
        if (flush) begin
            iss_valid_d = 1'b0;
        end else if (deq_fire) begin
            iss_valid_d      = 1'b1;
            iss_data_d       = deq_data;
            iss_data_d[S1R]  = 1'b1;
            iss_data_d[S2R]  = 1'b1;
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end
    end

`ifdef IIQ_SPEC_WAKEUP_EN
    // deq_fire already excludes flush, so the self-wake lives exactly one cycle.
    assign self_valid_d = deq_fire & deq_data[DV];
    assign self_tag_d   = deq_data[DT +: TAG_WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            iss_valid_q  <= 1'b0;
            iss_data_q   <= '0;
`ifdef IIQ_SPEC_WAKEUP_EN
            self_valid_q <= 1'b0;
            self_tag_q   <= '0;
`endif
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_data_q   <= iss_data_d;
`ifdef IIQ_SPEC_WAKEUP_EN
            self_valid_q <= self_valid_d;
            self_tag_q   <= self_tag_d;
`endif
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_data  = iss_data_q;

endmodule

// File: tb/tb_iiq_issue_scheduler.sv
// Directed bench for iiq_issue_scheduler with a shifting queue model and an issue scoreboard.
module tb_iiq_issue_scheduler;
    import iiq_pkg::*;

    localparam int N  = 8;
    localparam int EW = $bits(iiq_entry_t);
    localparam int CW = $clog2(N) + 1;

    logic              clk = 1'b0;
    logic              rst_aL, flush, deq_ready, deq_valid, cdb_valid, iss_valid, iss_ready;
    logic [N*EW-1:0]   entry_douts, wr_data;
    logic [CW-1:0]     cnt;
    logic [N-1:0]      deq_sel_onehot, wr_en;
    logic [EW-1:0]     deq_data, iss_data;
    logic [4:0]        cdb_tag;

    iiq_entry_t ent [N];
    iiq_entry_t sbq [$];
    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    iiq_issue_scheduler dut (
        .clk(clk), .rst_aL(rst_aL), .flush(flush),
        .entry_douts(entry_douts), .entry_count(cnt),
        .deq_ready(deq_ready), .deq_sel_onehot(deq_sel_onehot),
        .deq_valid(deq_valid), .deq_data(deq_data),
        .wr_en(wr_en), .wr_data(wr_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data)
    );

    // Queue side: present entries, answer the one-hot select.
    always_comb begin
        entry_douts = '0;
        for (int i = 0; i < N; i++) entry_douts[i*EW +: EW] = ent[i];
    end
    always_comb begin
        deq_data = '0;
        for (int i = 0; i < N; i++) if (deq_sel_onehot[i]) deq_data = ent[i];
    end
    assign deq_valid = |deq_sel_onehot;

    function automatic iiq_entry_t mk(logic [4:0] t1, logic r1, logic [4:0] t2, logic r2,
                                      logic [4:0] dt, logic dv, logic [31:0] p);
        iiq_entry_t e;
        e.src1_tag = t1; e.src1_ready = r1; e.src2_tag = t2; e.src2_ready = r2;
        e.dst_tag = dt; e.dst_valid = dv; e.payload = p;
        return e;
    endfunction

    function automatic iiq_entry_t issued(iiq_entry_t e);
        e.src1_ready = 1'b1;
        e.src2_ready = 1'b1;
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the queue model removes whatever was dequeued at that edge.
    task automatic tick();
        logic         fire;
        logic [N-1:0] s;
        int           idx;
        fire = rst_aL & deq_ready & deq_valid;
        s    = deq_sel_onehot;
        @(posedge clk);
        #2;
        if (fire) begin
            idx = 0;
            for (int i = N-1; i >= 0; i--) if (s[i]) idx = i;
            for (int j = idx; j < N-1; j++) ent[j] = ent[j+1];
            ent[N-1] = '0;
            cnt = cnt - CW'(1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_aL && iss_valid && iss_ready && !flush) begin
            if (sbq.size() == 0) chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
            else chk("iss_data_sb", 64'(iss_data), 64'(sbq.pop_front()));
        end
    end

    initial begin
        rst_aL = 1'b0; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; iss_ready = 1'b1;
        for (int i = 0; i < N; i++) ent[i] = '0;
        ent[0] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b0, 32'hA0);
        ent[1] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b0, 32'hA1);
        ent[2] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b0, 32'hA2);
        cnt = CW'(3);
        tick(); tick();
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_iss_data", 64'(iss_data), 64'd0);

        rst_aL = 1'b1; #1;
        chk("sel_after_rst", 64'(deq_sel_onehot), 64'h01);
        sbq.push_back(issued(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b0, 32'hA0)));
        tick();
        cnt = '0; cdb_valid = 1'b1; cdb_tag = 5'd1; #1;
        chk("iss_valid_first", 64'(iss_valid), 64'd1);
        chk("cnt0_no_sel", 64'(deq_sel_onehot), 64'd0);
        chk("cnt0_no_wr", 64'(wr_en), 64'd0);
        tick();

        // Only entry 2 ready.
        cdb_valid = 1'b0;
        ent[0] = mk(5'd3, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 32'hB0);
        ent[1] = mk(5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 32'hB1);
        ent[2] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hB2);
        cnt = CW'(3); #1;
        chk("sel_entry2", 64'(deq_sel_onehot), 64'h04);
        chk("no_wake_wr", 64'(wr_en), 64'd0);
        sbq.push_back(issued(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hB2)));
        tick();

        // Same-cycle CDB bypass into select.
        ent[0] = mk(5'd3, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 32'hC0);
        ent[1] = mk(5'd7, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 32'hC1);
        cnt = CW'(2); cdb_valid = 1'b1; cdb_tag = 5'd7; #1;
        chk("bypass_sel", 64'(deq_sel_onehot), 64'h02);
        chk("bypass_no_wr", 64'(wr_en), 64'd0);
        sbq.push_back(issued(mk(5'd7, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 32'hC1)));
        tick();
        cdb_valid = 1'b0; #1;
        chk("bypass_iss_valid", 64'(iss_valid), 64'd1);
        chk("bypass_src1_rdy", 64'(iss_data[5]), 64'd1);

        // Wakeup write without select (src2 still pending).
        ent[1] = mk(5'd7, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 32'hD1);
        cnt = CW'(2); cdb_valid = 1'b1; cdb_tag = 5'd7; #1;
        chk("wake_no_sel", 64'(deq_sel_onehot), 64'd0);
        chk("wake_wr_en", 64'(wr_en), 64'h02);
        chk("wake_wr_data", 64'(wr_data[1*EW +: EW]), 64'(mk(5'd7, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 32'hD1)));
        tick();

        // One tag matches both sources; flush blocks the select so the write is visible.
        ent[0] = mk(5'd8, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 32'hE0);
        cnt = CW'(1); cdb_tag = 5'd8; flush = 1'b1; #1;
        chk("both_no_sel", 64'(deq_sel_onehot), 64'd0);
        chk("both_wr_en", 64'(wr_en), 64'h01);
        chk("both_wr_data", 64'(wr_data[0 +: EW]), 64'(mk(5'd8, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 32'hE0)));
        tick();
        flush = 1'b0; cdb_valid = 1'b0;

        // Backpressure: hold issue register, then reload on the release cycle.
        ent[0] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hF0);
        ent[1] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hF1);
        ent[2] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hF2);
        cnt = CW'(3); #1;
        chk("hold_first_sel", 64'(deq_sel_onehot), 64'h01);
        sbq.push_back(issued(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hF0)));
        tick();
        iss_ready = 1'b0; #1;
        chk("hold_deq_ready", 64'(deq_ready), 64'd0);
        chk("hold_no_sel", 64'(deq_sel_onehot), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_valid", 64'(iss_valid), 64'd1);
            chk("hold_data", 64'(iss_data), 64'(issued(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hF0))));
        end
        iss_ready = 1'b1; #1;
        chk("release_deq_ready", 64'(deq_ready), 64'd1);
        chk("release_sel", 64'(deq_sel_onehot), 64'h01);
        sbq.push_back(issued(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'hF1)));
        tick();
        cnt = '0;
        tick();

        // Flush with a held op and ready entries.
        ent[0] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h60);
        cnt = CW'(1);
        sbq.push_back(issued(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h60)));
        tick();
        iss_ready = 1'b0;
        ent[0] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 32'h61);
        cnt = CW'(1); flush = 1'b1; #1;
        chk("flush_deq_ready", 64'(deq_ready), 64'd0);
        chk("flush_no_sel", 64'(deq_sel_onehot), 64'd0);
        tick();
        cnt = '0; flush = 1'b0; #1;
        chk("flush_iss_clr", 64'(iss_valid), 64'd0);
        sbq.delete();
        iss_ready = 1'b1;

        // Dependent op on the just-issued producer's dst_tag, no CDB.
        ent[0] = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 32'h70);
        ent[1] = mk(5'd4, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 32'h71);
        cnt = CW'(2); #1;
        chk("prod_sel", 64'(deq_sel_onehot), 64'h01);
        sbq.push_back(issued(mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 32'h70)));
        tick();
`ifdef IIQ_SPEC_WAKEUP_EN
        #1;
        chk("selfwake_sel", 64'(deq_sel_onehot), 64'h01);
        sbq.push_back(issued(mk(5'd4, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 32'h71)));
        tick();
`else
        #1;
        chk("no_selfwake_sel", 64'(deq_sel_onehot), 64'h00);
`endif
        cnt = '0;
        tick(); tick(); tick();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
